uart_tx_param: RTL and testbench
================================

# uart_tx_param

Parametrised UART transmitter; next generation of the fixed 8-bit even-parity transmitter. It accepts a data word over a valid/ready handshake and serialises it LSB-first with configurable data width, parity mode and stop-bit count. Bit timing comes from an integrated baud divider, and back-to-back frames are supported with no idle gap. It sits between the host-side data source and the serial pin, replacing the separate controller/PISO/parity/mux chain.

## Interface
- `DATA_BITS`, default 8: data bits per frame; legal range 5–9.
- `PARITY_MODE`, default 1: parity selection; 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, default 1: number of stop bits; legal values 1 or 2.
- `CLKS_PER_BIT`, default 16: `clk` cycles per bit; must be ≥ 2.
- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-low reset.
- `tx_valid` in 1: `tx_data` is valid.
- `tx_data` in `DATA_BITS`: word to send; sampled only on acceptance.
- `tx_ready` out 1: transmitter can accept a word this cycle.
- `fout` out 1: serial line; idle/mark = 1.
- `tx_busy` out 1: a frame or break is in progress.
- `tx_done` out 1: one-cycle pulse on the final cycle of the last stop bit.
- `tx_break` in 1: break request; present only with `UART_TX_BREAK_EN`.

## Operation
- **Acceptance.** A word is accepted when `tx_valid && tx_ready` at a rising edge. `tx_data` is captured into the shift register, and `tx_data` is don't-care at all other times.
- **States:** IDLE → START → DATA → PARITY → STOP → IDLE.
  - PARITY is skipped when `PARITY_MODE == 0`.
  - BREAK and BREAK_MARK states exist only with the macro.
- **Frame content.**
  - START drives 0.
  - DATA drives `shreg[0]` and shifts right each bit; `DATA_BITS` bits are sent.
  - PARITY drives the XOR of the captured word for even parity, or its inverse for odd parity.
  - STOP drives 1 for `STOP_BITS` bits.
- **Baud counter.** Width is `$clog2(CLKS_PER_BIT)`. It clears on acceptance and on every bit boundary. A bit ends when the counter equals `CLKS_PER_BIT - 1`.
- **Bit counter.** Width is `$clog2(DATA_BITS+1)`. It counts data bits and is reused for stop bits.
- **`tx_ready`** = (state == IDLE and no break pending) OR (state == STOP, last stop bit, final cycle). This is combinational from state registers only.
- **Back-to-back.** An acceptance on the final STOP cycle goes directly to START; no idle cycle is inserted.
- **`tx_busy`** = (state != IDLE).
- **Reset values.** `fout` = 1, `tx_ready` = 1, `tx_busy` = 0, `tx_done` = 0. State is IDLE and all counters are 0.
- **Reset mid-frame.** The in-flight frame is dropped without completion. On the cycle after the reset edge, `fout` = 1 and the state is IDLE.
- **`tx_valid` while not ready.** Ignored; the word is not captured. The source must hold `tx_valid`.

## Timing
- **Output timing.** `fout` is registered. START begins on the cycle after acceptance.
- **Frame length** = `CLKS_PER_BIT` × (1 + `DATA_BITS` + P + `STOP_BITS`), where P = (`PARITY_MODE != 0`).
- **Completion.** `tx_done` is asserted on the final cycle of the frame, coincident with `tx_ready` high in STOP.
- **Throughput.** Continuous `tx_valid` gives one frame per frame-length, with no gaps.

## Configuration
- **`UART_TX_BREAK_EN` defined:**
  - `tx_break` port exists.
  - Break sampled in IDLE enters BREAK: `fout` = 0, `tx_ready` = 0, `tx_busy` = 1 while `tx_break` stays high.
  - Break asserted mid-frame is held pending until the frame completes, and `tx_ready` is held low on the final STOP cycle.
  - On release, the block enters BREAK_MARK: `fout` = 1 for `STOP_BITS` × `CLKS_PER_BIT` cycles, then IDLE.
- **Not defined:** no `tx_break` port, no BREAK states; behaviour is otherwise identical.

## Structure
- **`uart_pkg`:**
  - State enum `uart_tx_state_t`.
  - Parity constants `PAR_NONE` / `PAR_EVEN` / `PAR_ODD`.
  - Parity function `uart_parity(word, mode)`, shared with the receiver.
- **Sub-module `uart_baud_gen`:** counter with synchronous clear and a `bit_end` pulse output, parametrised by `CLKS_PER_BIT`.
- **Top:** FSM, shift register, bit counter and output register.

## Test plan
- **Basic frame.** `DATA_BITS`=8, even parity, `STOP_BITS`=1, `CLKS_PER_BIT`=4. Send 0xA5.
  - `fout` bits: 0,1,0,1,0,0,1,0,1,0,1, each held 4 cycles (44 cycles total).
  - `tx_done` pulses at cycle 44 after acceptance.
- **Odd parity, two stop bits, 7-bit data.** Send 0x03.
  - `fout` bits: 0,1,1,0,0,0,0,0,1,1,1.
  - Frame is 44 cycles at `CLKS_PER_BIT`=4.
- **Back-to-back.** `tx_valid` held high with 0x00 then 0xFF.
  - The second START follows the first frame's final stop cycle with zero idle cycles.
  - `tx_ready` high for exactly 1 cycle per frame.
- **Reset mid-frame.** Assert `reset` low at bit 4 of a frame.
  - Next cycle: `fout` = 1, `tx_busy` = 0, `tx_ready` = 1.
  - A new frame sent after reset transmits correctly.
- **No parity, 5 bits, `CLKS_PER_BIT`=2.** Send 0x1F.
  - 7 bits, 14 cycles total.
  - `tx_valid` asserted while busy causes no capture.
- **Break (`UART_TX_BREAK_EN`).** Raise `tx_break` mid-frame for 20 cycles.
  - The frame completes first, then `fout` = 0 while `tx_break` is held.
  - After release: `fout` = 1 for `STOP_BITS` × `CLKS_PER_BIT` cycles, then `tx_ready` = 1.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state type, parity constants and parity helper
// Break states are present only when UART_TX_BREAK_EN is defined.
package uart_pkg;

   localparam int MAX_DATA_BITS = 9;

   localparam logic [1:0] PAR_NONE = 2'd0;
   localparam logic [1:0] PAR_EVEN = 2'd1;
   localparam logic [1:0] PAR_ODD  = 2'd2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
`ifdef UART_TX_BREAK_EN
      ,
      ST_BREAK,
      ST_BREAK_MARK
`endif
   } uart_tx_state_t;

   // Word is zero-extended by the caller, so the upper bits never disturb the XOR.
   function automatic logic uart_parity(input logic [MAX_DATA_BITS-1:0] word,
                                        input logic [1:0]               mode);
      return (^word) ^ (mode == PAR_ODD);
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-period counter with synchronous clear and bit_end pulse
module uart_baud_gen #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic i_clear,
   output logic o_bit_end
);

   localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] r_count;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_count <= '0;
      end else if (i_clear || o_bit_end) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + CW'(1);
      end
   end

   assign o_bit_end = (r_count == LAST);

endmodule

// File: rtl/uart_tx_param.sv
// rtl/uart_tx_param.sv - parametrised UART transmitter (FSM, shift register, bit counter)
// Optional line-break generation is enabled by defining UART_TX_BREAK_EN.
module uart_tx_param
   import uart_pkg::*;
#(
   parameter int DATA_BITS    = 8,
   parameter int PARITY_MODE  = 1,
   parameter int STOP_BITS    = 1,
   parameter int CLKS_PER_BIT = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 tx_valid,
   input  logic [DATA_BITS-1:0] tx_data,
`ifdef UART_TX_BREAK_EN
   input  logic                 tx_break,
`endif
   output logic                 tx_ready,
   output logic                 fout,
   output logic                 tx_busy,
   output logic                 tx_done
);

   localparam int               BC_W      = $clog2(DATA_BITS + 1);
   localparam logic [BC_W-1:0]  LAST_DATA = BC_W'(DATA_BITS - 1);
   localparam logic [BC_W-1:0]  LAST_STOP = BC_W'(STOP_BITS - 1);
   localparam logic [1:0]       PAR_SEL   = 2'(PARITY_MODE);
   localparam bit               HAS_PAR   = (PAR_SEL != PAR_NONE);

   uart_tx_state_t            r_state;
   logic                      r_fout;
   logic [DATA_BITS-1:0]      r_shreg;
   logic                      r_par;
   logic [BC_W-1:0]           r_bitcnt;
`ifdef UART_TX_BREAK_EN
   logic                      r_brk_pend;
`endif

   logic                      w_bit_end;
   logic                      w_last_data;
   logic                      w_last_stop;
   logic                      w_frame_end;
   logic                      w_accept;
   logic                      w_clear;
   logic [MAX_DATA_BITS-1:0]  w_data_ext;

   always_comb begin
      w_data_ext                = '0;
      w_data_ext[DATA_BITS-1:0] = tx_data;
   end

   assign w_last_data = (r_bitcnt == LAST_DATA);
   assign w_last_stop = (r_bitcnt == LAST_STOP);
   assign w_frame_end = (r_state == ST_STOP) && w_last_stop && w_bit_end;

`ifdef UART_TX_BREAK_EN
   assign tx_ready = ((r_state == ST_IDLE) || w_frame_end) && !r_brk_pend;
   assign w_clear  = (r_state == ST_IDLE) || (r_state == ST_BREAK) || w_accept;
`else
   assign tx_ready = (r_state == ST_IDLE) || w_frame_end;
   assign w_clear  = (r_state == ST_IDLE) || w_accept;
`endif

   assign w_accept = tx_valid && tx_ready;
   assign tx_busy  = (r_state != ST_IDLE);
   assign tx_done  = w_frame_end;
   assign fout     = r_fout;

   uart_baud_gen #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk      (clk),
      .reset    (reset),
      .i_clear  (w_clear),
      .o_bit_end(w_bit_end)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state  <= ST_IDLE;
         r_fout   <= 1'b1;
         r_shreg  <= '0;
         r_par    <= 1'b0;
         r_bitcnt <= '0;
`ifdef UART_TX_BREAK_EN
         r_brk_pend <= 1'b0;
`endif
      end else begin
`ifdef UART_TX_BREAK_EN
         // A break seen mid-frame waits until the frame's last stop bit is out.
         if (tx_break && (r_state inside {ST_START, ST_DATA, ST_PARITY, ST_STOP}))
            r_brk_pend <= 1'b1;
`endif
         // Acceptance happens only in IDLE or on the final stop cycle; both lead to START.
         if (w_accept) begin
            r_state  <= ST_START;
            r_fout   <= 1'b0;
            r_shreg  <= tx_data;
            r_par    <= uart_parity(w_data_ext, PAR_SEL);
            r_bitcnt <= '0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  r_fout <= 1'b1;
`ifdef UART_TX_BREAK_EN
                  if (tx_break || r_brk_pend) begin
                     r_state    <= ST_BREAK;
                     r_fout     <= 1'b0;
                     r_brk_pend <= 1'b0;
                  end
`endif
               end
               ST_START: begin
                  if (w_bit_end) begin
                     r_state  <= ST_DATA;
                     r_fout   <= r_shreg[0];
                     r_shreg  <= r_shreg >> 1;
                     r_bitcnt <= '0;
                  end
               end
               ST_DATA: begin
                  if (w_bit_end) begin
                     if (w_last_data) begin
                        r_bitcnt <= '0;
                        if (HAS_PAR) begin
                           r_state <= ST_PARITY;
                           r_fout  <= r_par;
                        end else begin
                           r_state <= ST_STOP;
                           r_fout  <= 1'b1;
                        end
                     end else begin
                        r_fout   <= r_shreg[0];
                        r_shreg  <= r_shreg >> 1;
                        r_bitcnt <= r_bitcnt + BC_W'(1);
                     end
                  end
               end
               ST_PARITY: begin
                  if (w_bit_end) begin
                     r_state  <= ST_STOP;
                     r_fout   <= 1'b1;
                     r_bitcnt <= '0;
                  end
               end
               ST_STOP: begin
                  if (w_bit_end) begin
                     if (w_last_stop) begin
                        r_bitcnt <= '0;
`ifdef UART_TX_BREAK_EN
                        if (r_brk_pend) begin
                           r_state    <= ST_BREAK;
                           r_fout     <= 1'b0;
                           r_brk_pend <= 1'b0;
                        end else begin
                           r_state <= ST_IDLE;
                           r_fout  <= 1'b1;
                        end
`else
                        r_state <= ST_IDLE;
                        r_fout  <= 1'b1;
`endif
                     end else begin
                        r_bitcnt <= r_bitcnt + BC_W'(1);
                     end
                  end
               end
`ifdef UART_TX_BREAK_EN
               ST_BREAK: begin
                  r_fout <= 1'b0;
                  if (!tx_break) begin
                     r_state  <= ST_BREAK_MARK;
                     r_fout   <= 1'b1;
                     r_bitcnt <= '0;
                  end
               end
               ST_BREAK_MARK: begin
                  r_fout <= 1'b1;
                  if (w_bit_end) begin
                     if (w_last_stop) begin
                        r_state  <= ST_IDLE;
                        r_bitcnt <= '0;
                     end else begin
                        r_bitcnt <= r_bitcnt + BC_W'(1);
                     end
                  end
               end
`endif
               default: begin
                  r_state <= ST_IDLE;
                  r_fout  <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_param.sv
// tb/tb_uart_tx_param.sv - directed self-checking bench for uart_tx_param
// Break scenario is exercised only when UART_TX_BREAK_EN is defined.
module tb_uart_tx_param;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic       va, vb, vc;
   logic [7:0] da;
   logic [6:0] db;
   logic [4:0] dc;
   logic       ra, rb, rc;
   logic       fa, fb, fc;
   logic       ba, bb, bc;
   logic       dna, dnb, dnc;
`ifdef UART_TX_BREAK_EN
   logic       brk_a;
`endif

   int n_cmp;
   int n_bad;
   int sel;

   logic o_fout, o_ready, o_busy, o_done;
   logic cap_fout  [0:127];
   logic cap_ready [0:127];
   logic cap_busy  [0:127];
   logic cap_done  [0:127];

   uart_tx_param #(.DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1), .CLKS_PER_BIT(4)) dut_a (
      .clk(clk), .reset(reset), .tx_valid(va), .tx_data(da),
`ifdef UART_TX_BREAK_EN
      .tx_break(brk_a),
`endif
      .tx_ready(ra), .fout(fa), .tx_busy(ba), .tx_done(dna));

   uart_tx_param #(.DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(2), .CLKS_PER_BIT(4)) dut_b (
      .clk(clk), .reset(reset), .tx_valid(vb), .tx_data(db),
`ifdef UART_TX_BREAK_EN
      .tx_break(1'b0),
`endif
      .tx_ready(rb), .fout(fb), .tx_busy(bb), .tx_done(dnb));

   uart_tx_param #(.DATA_BITS(5), .PARITY_MODE(0), .STOP_BITS(1), .CLKS_PER_BIT(2)) dut_c (
      .clk(clk), .reset(reset), .tx_valid(vc), .tx_data(dc),
`ifdef UART_TX_BREAK_EN
      .tx_break(1'b0),
`endif
      .tx_ready(rc), .fout(fc), .tx_busy(bc), .tx_done(dnc));

   always_comb begin
      o_fout = fa; o_ready = ra; o_busy = ba; o_done = dna;
      if (sel == 1) begin
         o_fout = fb; o_ready = rb; o_busy = bb; o_done = dnb;
      end else if (sel == 2) begin
         o_fout = fc; o_ready = rc; o_busy = bc; o_done = dnc;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic set_valid(input logic v, input logic [8:0] d);
      case (sel)
         0:       begin va = v; da = d[7:0]; end
         1:       begin vb = v; db = d[6:0]; end
         default: begin vc = v; dc = d[4:0]; end
      endcase
   endtask

   // Called at posedge+1; returns at posedge+1 of cycle 1 after acceptance.
   task automatic send(input string tag, input logic [8:0] d);
      int t;
      t = 0;
      set_valid(1'b1, d);
      while (!o_ready && t < 200) begin
         @(posedge clk); #1;
         t++;
      end
      check({tag, "_ready"}, 32'(o_ready), 32'd1);
      @(posedge clk); #1;
      set_valid(1'b0, 9'h000);
   endtask

   task automatic capture(input int n, input int poke_lo, input int poke_hi);
      for (int c = 1; c <= n; c++) begin
         if (c == poke_lo) set_valid(1'b1, 9'h000);
         if (c == poke_hi) set_valid(1'b0, 9'h000);
         cap_fout[c]  = o_fout;
         cap_ready[c] = o_ready;
         cap_busy[c]  = o_busy;
         cap_done[c]  = o_done;
         @(posedge clk); #1;
      end
   endtask

   task automatic check_frame(input string tag, input string exp, input int cpb, input int base);
      logic [31:0] got, want;
      for (int k = 0; k < exp.len(); k++) begin
         got  = '0;
         want = '0;
         for (int j = 0; j < cpb; j++) begin
            got  = {got[30:0], cap_fout[base + k*cpb + j + 1]};
            want = {want[30:0], (exp[k] == "1")};
         end
         check($sformatf("%s_bit%0d", tag, k), got, want);
      end
   endtask

   task automatic check_done(input string tag, input int n, input int exp_pos, input int exp_cnt);
      int pos, cnt;
      pos = 0;
      cnt = 0;
      for (int c = 1; c <= n; c++) begin
         if (cap_done[c]) begin
            cnt++;
            if (pos == 0) pos = c;
         end
      end
      check({tag, "_done_pos"}, 32'(pos), 32'(exp_pos));
      check({tag, "_done_cnt"}, 32'(cnt), 32'(exp_cnt));
   endtask

   initial begin
      int rdy_cnt;
      logic [31:0] pk;
      n_cmp = 0; n_bad = 0; sel = 0;
      reset = 1'b0;
      va = 0; vb = 0; vc = 0; da = '0; db = '0; dc = '0;
`ifdef UART_TX_BREAK_EN
      brk_a = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1;
      check("rst_fout_a",  32'(fa),  32'd1);
      check("rst_ready_a", 32'(ra),  32'd1);
      check("rst_busy_a",  32'(ba),  32'd0);
      check("rst_done_a",  32'(dna), 32'd0);
      check("rst_fout_b",  32'(fb),  32'd1);
      check("rst_ready_c", 32'(rc),  32'd1);
      reset = 1'b1;
      @(posedge clk); #1;

      // 8 bits, even parity, 1 stop, 4 clk/bit
      sel = 0;
      send("a", 9'h0A5);
      capture(46, 0, 0);
      check_frame("a", "01010010101", 4, 0);
      check_done("a", 46, 44, 1);
      check("a_busy_mid",  32'(cap_busy[20]), 32'd1);
      check("a_ready_mid", 32'(cap_ready[20]), 32'd0);
      check("a_ready_end", 32'(cap_ready[44]), 32'd1);
      check("a_idle_fout", 32'(cap_fout[45]), 32'd1);
      check("a_idle_busy", 32'(cap_busy[45]), 32'd0);

      // 7 bits, odd parity, 2 stop
      sel = 1;
      send("b", 9'h003);
      capture(46, 0, 0);
      check_frame("b", "01100000111", 4, 0);
      check_done("b", 46, 44, 1);
      check("b_ready_stop1", 32'(cap_ready[40]), 32'd0);
      check("b_ready_stop2", 32'(cap_ready[44]), 32'd1);
      check("b_idle_busy",   32'(cap_busy[45]), 32'd0);

      // 5 bits, no parity, 2 clk/bit; valid pulsed while busy must be ignored
      sel = 2;
      send("c", 9'h01F);
      capture(16, 3, 9);
      check_frame("c", "0111111", 2, 0);
      check_done("c", 16, 14, 1);
      check("c_ready_busy", 32'(cap_ready[5]), 32'd0);
      check("c_idle_fout",  32'(cap_fout[15]), 32'd1);
      check("c_idle_busy",  32'(cap_busy[15]), 32'd0);

      // back-to-back 0x00 then 0xFF with valid held
      sel = 0;
      set_valid(1'b1, 9'h000);
      check("b2b_ready0", 32'(o_ready), 32'd1);
      @(posedge clk); #1;
      set_valid(1'b1, 9'h0FF);
      capture(90, 0, 45);
      check_frame("b2b1", "00000000001", 4, 0);
      check_frame("b2b2", "01111111101", 4, 44);
      check_done("b2b", 88, 44, 2);
      rdy_cnt = 0;
      for (int c = 1; c <= 88; c++) if (cap_ready[c]) rdy_cnt++;
      check("b2b_ready_cnt", 32'(rdy_cnt), 32'd2);
      check("b2b_ready88",   32'(cap_ready[88]), 32'd1);
      check("b2b_idle_busy", 32'(cap_busy[89]), 32'd0);

      // reset during bit 4 of a frame, then a clean frame
      send("r", 9'h052);
      capture(16, 0, 0);
      check("r_busy_mid",  32'(o_busy), 32'd1);
      check("r_fout_bit4", 32'(o_fout), 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      check("r_fout",  32'(o_fout),  32'd1);
      check("r_busy",  32'(o_busy),  32'd0);
      check("r_ready", 32'(o_ready), 32'd1);
      check("r_done",  32'(o_done),  32'd0);
      send("r2", 9'h03C);
      capture(46, 0, 0);
      check_frame("r2", "00011110001", 4, 0);
      check_done("r2", 46, 44, 1);

`ifdef UART_TX_BREAK_EN
      // break raised mid-frame and held past the frame end
      send("k", 9'h000);
      for (int c = 1; c <= 56; c++) begin
         if (c == 30) brk_a = 1'b1;
         if (c == 50) brk_a = 1'b0;
         cap_fout[c]  = o_fout;
         cap_ready[c] = o_ready;
         cap_busy[c]  = o_busy;
         cap_done[c]  = o_done;
         @(posedge clk); #1;
      end
      check_frame("k", "00000000001", 4, 0);
      check("k_ready_end", 32'(cap_ready[44]), 32'd0);
      check("k_done_end",  32'(cap_done[44]),  32'd1);
      pk = '0;
      for (int c = 45; c <= 50; c++) pk = {pk[30:0], cap_fout[c]};
      check("k_brk_low", pk, 32'h0);
      pk = '0;
      for (int c = 45; c <= 54; c++) pk = {pk[30:0], cap_busy[c]};
      check("k_brk_busy", pk, 32'h3FF);
      pk = '0;
      for (int c = 51; c <= 54; c++) pk = {pk[30:0], cap_fout[c]};
      check("k_mark_high", pk, 32'hF);
      pk = '0;
      for (int c = 51; c <= 54; c++) pk = {pk[30:0], cap_ready[c]};
      check("k_mark_ready", pk, 32'h0);
      check("k_idle_ready", 32'(cap_ready[55]), 32'd1);
      check("k_idle_busy",  32'(cap_busy[55]),  32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
